// File: rtl/cla_add_arbiter_pkg.sv
// Shared constants, helper and tag type for the shared-adder arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_add_arbiter_pkg;

  localparam int CLA_DATA_W  = 32;
  localparam int CLA_ADD_LAT = 2;
  // Tag id field is sized for the largest supported requester count (8).
  localparam int TAG_ID_W    = 3;

  // Index width for n requesters; never below 1 bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/cla_add_arbiter_rr.sv
// Round-robin arbiter: picks the first set request at or after ptr, wrapping.
// Latency: grant is combinational; ptr advances on the edge of an accepted grant.
// Backpressure: ptr holds while accept is low.
// Ports: clk, rst, req vector, accept; gnt one-hot, gnt_idx index, any (some request set).
module cla_add_arbiter_rr #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    accept,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_idx,
  output logic                    any
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;

  always_comb begin
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // Explicit wrap keeps non-power-of-2 NREQ correct.
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IW'(j);
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_cla_32.sv
// Two-stage 32-bit carry-lookahead adder: operand registers, then result registers.
// Latency: 2 clock edges from operand drive to sum/cout at the outputs.
// Backpressure: none; accepts new operands every cycle.
// Ports: clk, rst (sync, active high), a/b/cin operands, sum/cout registered result.
module pipe_cla_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] a_q, b_q;
  logic        cin_q;
  logic [31:0] g, p;
  logic [32:0] c;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
    end
  end

  // Generate/propagate carry recurrence.
  always_comb begin
    g    = a_q & b_q;
    p    = a_q ^ b_q;
    c    = '0;
    c[0] = cin_q;
    for (int i = 0; i < 32; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= p ^ c[31:0];
      cout <= c[32];
    end
  end

endmodule

// File: rtl/cla_add_arbiter.sv
// Shares one pipelined adder among NREQ requesters, one round-robin grant per cycle,
// results tagged back to the issuer. Latency: handshake in cycle C -> rsp_valid in C+ADD_LAT+1.
// Backpressure: req_ready gated by en; responses are never stalled.
// Ports: clk, rst; en, req_valid/ready/a/b/cin (packed per requester); add_a/b/cin to adder,
// add_sum/cout from adder; rsp_valid/id/sum/cout; busy; grant_cnt (16-bit wrapping).
module cla_add_arbiter
  import cla_add_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DATA_W  = CLA_DATA_W,
  parameter int ADD_LAT = CLA_ADD_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ-1:0]          req_cin,
  output logic [DATA_W-1:0]        add_a,
  output logic [DATA_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [DATA_W-1:0]        add_sum,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_sum,
  output logic                     rsp_cout,
  output logic                     busy,
  output logic [15:0]              grant_cnt
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            any;
  logic            hs;
  tag_t            tag_q [ADD_LAT];

  assign hs        = en & any;
  assign req_ready = hs ? gnt : '0;

  cla_add_arbiter_rr #(.NREQ(NREQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .accept  (hs),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Operands stay zero when idle so the adder never sees stale or X data.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (hs) begin
      add_a   = req_a[int'(gnt_idx)*DATA_W +: DATA_W];
      add_b   = req_b[int'(gnt_idx)*DATA_W +: DATA_W];
      add_cin = req_cin[gnt_idx];
    end
  end

  // Tag pipe mirrors the adder depth; the last stage lines up with add_sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < ADD_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= {hs, TAG_ID_W'(gnt_idx)};
      for (int s = 1; s < ADD_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      grant_cnt <= '0;
    end else begin
      rsp_valid <= tag_q[ADD_LAT-1].vld;
      if (tag_q[ADD_LAT-1].vld) begin
        rsp_id   <= IW'(tag_q[ADD_LAT-1].id);
        rsp_sum  <= add_sum;
        rsp_cout <= add_cout;
      end
      if (hs) grant_cnt <= grant_cnt + 16'd1;
    end
  end

  always_comb begin
    busy = rsp_valid;
    for (int s = 0; s < ADD_LAT; s++) busy = busy | tag_q[s].vld;
  end

endmodule

// File: tb/tb_cla_add_arbiter.sv
// Directed bench for cla_add_arbiter driving a pipe_cla_32 adder.
// Latency: n/a.
// Backpressure: n/a.
module tb_cla_add_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ-1:0]      req_cin;
  logic [DW-1:0]        add_a, add_b, add_sum;
  logic                 add_cin, add_cout;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [DW-1:0]        rsp_sum;
  logic                 rsp_cout;
  logic                 busy;
  logic [15:0]          grant_cnt;

  always #5 clk = ~clk;

  cla_add_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADD_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy),
    .grant_cnt (grant_cnt)
  );

  pipe_cla_32 u_add (
    .clk  (clk),
    .rst  (rst),
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  typedef struct {
    int          id;
    logic [31:0] sum;
    logic        cout;
    int          due;
  } exp_t;

  exp_t            q[$];
  exp_t            mon_e;
  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              mptr = 0;
  bit              mon_on = 1'b0;
  logic [31:0]     a_v [NREQ];
  logic [31:0]     b_v [NREQ];
  logic [NREQ-1:0] cin_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: each expected entry must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (q.size() != 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_id",    {62'd0, rsp_id},    64'(mon_e.id));
        chk("rsp_sum",   {32'd0, rsp_sum},   {32'd0, mon_e.sum});
        chk("rsp_cout",  {63'd0, rsp_cout},  {63'd0, mon_e.cout});
      end else begin
        chk("rsp_idle", {63'd0, rsp_valid}, 64'd0);
      end
    end
  end

  // Drive one cycle of requests, check grant/operands against the bench model,
  // then advance to one time unit after the next rising edge.
  task automatic drive(input logic [NREQ-1:0] v, input logic e_in);
    int          g;
    bit          hs;
    logic [32:0] full;
    req_valid = v;
    en        = e_in;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = a_v[i];
      req_b[i*DW +: DW] = b_v[i];
      req_cin[i]        = cin_v[i];
    end
    #1;
    hs = 1'b0;
    g  = 0;
    if (e_in) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!hs && v[(mptr + k) % NREQ]) begin
          hs = 1'b1;
          g  = (mptr + k) % NREQ;
        end
      end
    end
    chk("req_ready", {60'd0, req_ready}, hs ? (64'd1 << g) : 64'd0);
    chk("add_a",   {32'd0, add_a},   hs ? {32'd0, a_v[g]} : 64'd0);
    chk("add_b",   {32'd0, add_b},   hs ? {32'd0, b_v[g]} : 64'd0);
    chk("add_cin", {63'd0, add_cin}, hs ? {63'd0, cin_v[g]} : 64'd0);
    if (hs) begin
      full = {1'b0, a_v[g]} + {1'b0, b_v[g]} + {32'd0, cin_v[g]};
      q.push_back('{id: g, sum: full[31:0], cout: full[32], due: cyc + 3});
      mptr = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    q.delete();
    mptr = 0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 32'h0; b_v[i] = 32'h0;
    end
    cin_v = '0;
    do_reset(2);

    // Reset state
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_id",    {62'd0, rsp_id},    64'd0);
    chk("rst_rsp_sum",   {32'd0, rsp_sum},   64'd0);
    chk("rst_rsp_cout",  {63'd0, rsp_cout},  64'd0);
    chk("rst_grant_cnt", {48'd0, grant_cnt}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    mon_on = 1'b1;

    // Single req0: 1 + FFFFFFFF -> sum 0, carry out
    a_v[0] = 32'h0000_0001; b_v[0] = 32'hFFFF_FFFF; cin_v[0] = 1'b0;
    drive(4'b0001, 1'b1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    chk("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t1_rsp_id",    {62'd0, rsp_id},    64'd0);
    chk("t1_rsp_sum",   {32'd0, rsp_sum},   64'h0);
    chk("t1_rsp_cout",  {63'd0, rsp_cout},  64'd1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);

    // All four valid for 8 cycles from a fresh pointer: 0,1,2,3,0,1,2,3
    do_reset(1);
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 32'h1111_1111 * (i + 1); b_v[i] = 32'h0F0F_0F0F << i; cin_v[i] = i[0];
    end
    for (int k = 0; k < 8; k++) begin
      req_valid = 4'b1111; en = 1'b1;
      #1;
      chk("t2_order", {60'd0, req_ready}, 64'd1 << (k % 4));
      drive(4'b1111, 1'b1);
    end
    repeat (4) drive(4'b0000, 1'b1);
    chk("t2_grant_cnt", {48'd0, grant_cnt}, 64'd8);

    // req2 alone: 7FFFFFFF + 0 + 1 -> 80000000, then ptr=3 favours req3 over req1
    a_v[2] = 32'h7FFF_FFFF; b_v[2] = 32'h0; cin_v[2] = 1'b1;
    drive(4'b0100, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    chk("t3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t3_rsp_id",    {62'd0, rsp_id},    64'd2);
    chk("t3_rsp_sum",   {32'd0, rsp_sum},   64'h8000_0000);
    chk("t3_rsp_cout",  {63'd0, rsp_cout},  64'd0);
    req_valid = 4'b1010; en = 1'b1;
    #1;
    chk("t3_ptr3_first", {60'd0, req_ready}, 64'b1000);
    drive(4'b1010, 1'b1);
    repeat (4) drive(4'b0000, 1'b1);

    // en low for 5 cycles with all valid: drain, busy falls after 3 cycles
    drive(4'b1111, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      chk("t4_busy", {63'd0, busy}, (k <= 3) ? 64'd1 : 64'd0);
      drive(4'b1111, 1'b0);
    end
    drive(4'b1111, 1'b1);
    repeat (4) drive(4'b0000, 1'b1);
    chk("t4_grant_cnt", {48'd0, grant_cnt}, 64'd12);

    // Reset one cycle after two grants: both results dropped
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b1);
    do_reset(1);
    for (int k = 0; k < 4; k++) begin
      chk("t5_no_rsp",    {63'd0, rsp_valid}, 64'd0);
      chk("t5_grant_cnt", {48'd0, grant_cnt}, 64'd0);
      drive(4'b0000, 1'b1);
    end
    chk("t5_busy",    {63'd0, busy},    64'd0);
    chk("t5_rsp_sum", {32'd0, rsp_sum}, 64'd0);
    req_valid = 4'b1010; en = 1'b1;
    #1;
    chk("t5_lowest_first", {60'd0, req_ready}, 64'b0010);
    drive(4'b1010, 1'b1);
    repeat (4) drive(4'b0000, 1'b1);

    // 65536+3 grants with random operands: counter wraps to 3
    do_reset(1);
    for (int n = 0; n < 65539; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a_v[i] = $urandom; b_v[i] = $urandom; cin_v[i] = 1'($urandom_range(0, 1));
      end
      drive(4'b1111, 1'b1);
    end
    repeat (4) drive(4'b0000, 1'b1);
    chk("t6_grant_cnt_wrap", {48'd0, grant_cnt}, 64'd3);
    chk("pending_rsp", 64'(q.size()), 64'd0);

    mon_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
